// File: rtl/itch_frame_scheduler.sv
// ITCH front-end sequencer: walks a 64-bit word stream, decodes 3-byte headers (including ones
// split across words), dispatches one-hot starts and streams body beats or skips bad messages.
`timescale 1ns/1ps
module itch_frame_scheduler #(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    output logic             in_ready,
    output logic [7:0]       start_o,
    output logic [7:0]       msg_type,
    output logic [15:0]      msg_len,
    output logic             body_valid,
    output logic [63:0]      body_data,
    output logic [2:0]       body_offset,
    output logic             body_last,
    input  logic             body_ready,
    output logic [CNT_W-1:0] unknown_cnt,
    output logic [CNT_W-1:0] bad_len_cnt,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_FETCH, S_HDR, S_HDR2, S_DISP, S_BODY, S_BFETCH, S_SKIP, S_SFETCH
    } state_t;

    localparam logic [1:0] CLS_KNOWN = 2'd0;
    localparam logic [1:0] CLS_UNK   = 2'd1;
    localparam logic [1:0] CLS_BAD   = 2'd2;

    state_t           r_state;
    logic [63:0]      r_cur;
    logic [2:0]       r_ptr;
    logic [2:0]       r_off;
    logic [2:0]       r_q;
    logic [15:0]      r_rem;
    logic [15:0]      r_hlo;
    logic             r_nf;
    logic [1:0]       r_cls;
    logic [7:0]       r_start;
    logic [7:0]       r_type;
    logic [15:0]      r_len;
    logic [CNT_W-1:0] r_unk;
    logic [CNT_W-1:0] r_bad;

    logic [23:0] w_hdr_cur;
    logic [23:0] w_hdr_spl;
    logic [23:0] w_hb;
    logic [15:0] w_len;
    logic [7:0]  w_type;
    logic [7:0]  w_oh;
    logic        w_badlen;
    logic        w_acc;
    logic        w_dec;
    logic        w_last;
    logic [3:0]  w_room;
    logic [3:0]  w_np;

    function automatic logic [7:0] type_onehot(input logic [7:0] t);
        logic [7:0] oh;
        case (t)
            8'h41:   oh = 8'h01;
            8'h46:   oh = 8'h02;
            8'h45:   oh = 8'h04;
            8'h43:   oh = 8'h08;
            8'h44:   oh = 8'h10;
            8'h52:   oh = 8'h20;
            8'h4F:   oh = 8'h40;
            8'h4C:   oh = 8'h80;
            default: oh = 8'h00;
        endcase
        return oh;
    endfunction

    // A split header is the two latched tail bytes of the old word followed by the new word's head.
    assign w_hdr_cur = 24'(r_cur >> {r_ptr, 3'b000});
    assign w_hdr_spl = 24'({in_data[15:0], r_hlo} >> {r_ptr[0], 3'b000});
    assign w_hb      = (r_state == S_HDR2) ? w_hdr_spl : w_hdr_cur;
    assign w_len     = w_hb[15:0];
    assign w_type    = w_hb[23:16];
    assign w_oh      = type_onehot(w_type);
    assign w_badlen  = (w_len == 16'd0) || (w_len > 16'(MAX_LEN));

    assign in_ready = (r_state == S_FETCH) || (r_state == S_HDR2) ||
                      (r_state == S_BFETCH) || (r_state == S_SFETCH);
    assign w_acc    = in_valid && in_ready;
    assign w_dec    = ((r_state == S_HDR) && (r_ptr < 3'd6)) || ((r_state == S_HDR2) && w_acc);
    assign w_room   = 4'd8 - {1'b0, r_off};
    assign w_last   = r_rem <= {12'd0, w_room};
    assign w_np     = {1'b0, r_off} + r_rem[3:0];

    assign busy        = r_state != S_FETCH;
    assign body_valid  = r_state == S_BODY;
    assign body_data   = r_cur;
    assign body_offset = body_valid ? r_off : 3'd0;
    assign body_last   = body_valid && w_last;
    assign start_o     = r_start;
    assign msg_type    = r_type;
    assign msg_len     = r_len;
    assign unknown_cnt = r_unk;
    assign bad_len_cnt = r_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cur   <= '0;
            r_ptr   <= '0;
            r_off   <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_hlo   <= '0;
            r_nf    <= 1'b0;
            r_cls   <= CLS_KNOWN;
            r_start <= '0;
            r_type  <= '0;
            r_len   <= '0;
            r_unk   <= '0;
            r_bad   <= '0;
        end else begin
            r_start <= 8'h00;
            case (r_state)
                S_FETCH: if (w_acc) begin
                    r_cur   <= in_data;
                    r_state <= S_HDR;
                end
                S_HDR: if (r_ptr >= 3'd6) begin
                    r_hlo   <= r_cur[63:48];
                    r_state <= S_HDR2;
                end else begin
                    r_state <= S_DISP;
                end
                S_HDR2: if (w_acc) begin
                    r_cur   <= in_data;
                    r_state <= S_DISP;
                end
                S_DISP: begin
                    // Zero-length headers resync two bytes on, just past the length field.
                    if ((r_cls == CLS_BAD) && (r_len == 16'd0)) begin
                        r_ptr   <= r_ptr + 3'd2;
                        r_state <= S_HDR;
                    end else if (r_rem == 16'd0) begin
                        r_ptr   <= r_nf ? 3'd0 : r_q;
                        r_state <= r_nf ? S_FETCH : S_HDR;
                    end else if (r_nf) begin
                        r_off   <= 3'd0;
                        r_state <= (r_cls == CLS_KNOWN) ? S_BFETCH : S_SFETCH;
                    end else begin
                        r_off   <= r_q;
                        r_state <= (r_cls == CLS_KNOWN) ? S_BODY : S_SKIP;
                    end
                end
                S_BODY: if (body_ready) begin
                    if (w_last) begin
                        r_ptr   <= w_np[3] ? 3'd0 : w_np[2:0];
                        r_state <= w_np[3] ? S_FETCH : S_HDR;
                    end else begin
                        r_rem   <= r_rem - {12'd0, w_room};
                        r_off   <= 3'd0;
                        r_state <= S_BFETCH;
                    end
                end
                S_BFETCH: if (w_acc) begin
                    r_cur   <= in_data;
                    r_state <= S_BODY;
                end
                S_SKIP: begin
                    if (w_last) begin
                        r_ptr   <= w_np[3] ? 3'd0 : w_np[2:0];
                        r_state <= w_np[3] ? S_FETCH : S_HDR;
                    end else begin
                        r_rem   <= r_rem - {12'd0, w_room};
                        r_off   <= 3'd0;
                        r_state <= S_SFETCH;
                    end
                end
                S_SFETCH: if (w_acc) begin
                    r_cur   <= in_data;
                    r_state <= S_SKIP;
                end
                default: r_state <= S_FETCH;
            endcase

            if (w_dec) begin
                r_len <= w_len;
                r_type <= w_type;
                r_rem <= w_len - 16'd1;
                r_q   <= r_ptr + 3'd3;
                r_nf  <= (r_state == S_HDR) && (r_ptr == 3'd5);
                if (w_badlen) begin
                    r_cls <= CLS_BAD;
                    if (r_bad != '1) r_bad <= r_bad + 1'b1;
                end else if (w_oh == 8'h00) begin
                    r_cls <= CLS_UNK;
                    if (r_unk != '1) r_unk <= r_unk + 1'b1;
                end else begin
                    r_cls   <= CLS_KNOWN;
                    r_start <= w_oh;
                end
            end
        end
    end

endmodule
